// File: rtl/du_issue_scheduler.sv
// Issue scheduler between the two decoder ways and Ex: orders the pair by pID, tracks pending
// rd writes per register, and grants 0..2 instructions per cycle in program order.
module du_issue_scheduler #(
  parameter int PID_W      = 2,
  parameter int SB_CNT_W   = 2,
  parameter bit DUAL_ISSUE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             way0_valid_i,
  input  logic [PID_W-1:0] way0_pID_i,
  input  logic [4:0]       way0_rs1Addr_i,
  input  logic             way0_rs1ReadEnable_i,
  input  logic [4:0]       way0_rs2Addr_i,
  input  logic             way0_rs2ReadEnable_i,
  input  logic [4:0]       way0_rdAddr_i,
  input  logic             way0_rdWrite_i,
  input  logic             way1_valid_i,
  input  logic [PID_W-1:0] way1_pID_i,
  input  logic [4:0]       way1_rs1Addr_i,
  input  logic             way1_rs1ReadEnable_i,
  input  logic [4:0]       way1_rs2Addr_i,
  input  logic             way1_rs2ReadEnable_i,
  input  logic [4:0]       way1_rdAddr_i,
  input  logic             way1_rdWrite_i,
  input  logic             ex_ready_i,
  input  logic             flush_i,
  input  logic [PID_W-1:0] flush_pID_i,
  input  logic             wb0_valid_i,
  input  logic [4:0]       wb0_rdAddr_i,
  input  logic             wb1_valid_i,
  input  logic [4:0]       wb1_rdAddr_i,
  output logic             way0_ready_o,
  output logic             way1_ready_o,
  output logic             slot0_valid_o,
  output logic             slot0_sel_o,
  output logic             slot1_valid_o,
  output logic             stall_o,
  output logic             sb_err_o
);

  localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;

  // Handshake: wayN is consumed in the cycle wayN_valid_i && wayN_ready_o; until then the
  // DU register holds that way stable, though it may drop valid without a grant.
  logic [PID_W-1:0]    exp_pid_q, exp_pid_d, exp_pid_inc;
  logic [SB_CNT_W-1:0] sb_cnt_q [32];
  logic [SB_CNT_W-1:0] sb_cnt_d [32];
  logic                sb_err_q, sb_err_d;

  logic [1:0]       v, e1, e2, w;
  logic [PID_W-1:0] pid [2];
  logic [4:0]       rs1 [2];
  logic [4:0]       rs2 [2];
  logic [4:0]       rd  [2];
  logic [1:0]       haz;
  logic             m0, m1, has_first, f, s, sec_cand, pair_dep, s0, s1;

  assign v      = {way1_valid_i, way0_valid_i};
  assign e1     = {way1_rs1ReadEnable_i, way0_rs1ReadEnable_i};
  assign e2     = {way1_rs2ReadEnable_i, way0_rs2ReadEnable_i};
  assign w      = {way1_rdWrite_i, way0_rdWrite_i};
  assign pid[0] = way0_pID_i;
  assign pid[1] = way1_pID_i;
  assign rs1[0] = way0_rs1Addr_i;
  assign rs1[1] = way1_rs1Addr_i;
  assign rs2[0] = way0_rs2Addr_i;
  assign rs2[1] = way1_rs2Addr_i;
  assign rd[0]  = way0_rdAddr_i;
  assign rd[1]  = way1_rdAddr_i;

  // Hazards use the registered counts only, so a same-cycle writeback never unblocks.
  always_comb begin
    haz = '0;
    for (int i = 0; i < 2; i++) begin
      haz[i] = (e1[i] && rs1[i] != 5'd0 && sb_cnt_q[rs1[i]] != '0) ||
               (e2[i] && rs2[i] != 5'd0 && sb_cnt_q[rs2[i]] != '0) ||
               (w[i]  && rd[i]  != 5'd0 && sb_cnt_q[rd[i]] == CNT_MAX);
    end
  end

  assign exp_pid_inc = exp_pid_q + PID_W'(1);
  assign m0          = way0_valid_i && (way0_pID_i == exp_pid_q);
  assign m1          = way1_valid_i && (way1_pID_i == exp_pid_q);
  assign has_first   = m0 | m1;
  assign f           = ~m0 & m1;
  assign s           = ~f;
  assign sec_cand    = v[s] && (pid[s] == exp_pid_inc);
  assign pair_dep    = w[f] && rd[f] != 5'd0 &&
                       ((e1[s] && rs1[s] == rd[f]) || (e2[s] && rs2[s] == rd[f]) ||
                        (w[s] && rd[s] == rd[f]));

  assign s0 = rst_n && has_first && !flush_i && ex_ready_i && !haz[f];
  assign s1 = s0 && DUAL_ISSUE && sec_cand && !haz[s] && !pair_dep;

  assign slot0_valid_o = s0;
  assign slot0_sel_o   = f;
  assign slot1_valid_o = s1;
  assign way0_ready_o  = (s0 && !f) || (s1 && !s);
  assign way1_ready_o  = (s0 && f) || (s1 && s);
  assign stall_o       = rst_n && (way0_valid_i || way1_valid_i) && !s0;
  assign sb_err_o      = sb_err_q;

  assign exp_pid_d = flush_i ? flush_pID_i : exp_pid_q + PID_W'(s0) + PID_W'(s1);

  always_comb begin : sb_next
    logic                inc;
    logic [1:0]          dec;
    logic [SB_CNT_W:0]   sum;
    sb_err_d = sb_err_q;
    inc      = 1'b0;
    dec      = '0;
    sum      = '0;
    for (int r = 0; r < 32; r++) begin
      sb_cnt_d[r] = sb_cnt_q[r];
      if (r != 0) begin
        inc = (s0 && w[f] && rd[f] == 5'(r)) || (s1 && w[s] && rd[s] == 5'(r));
        dec = {1'b0, wb0_valid_i && wb0_rdAddr_i == 5'(r)} +
              {1'b0, wb1_valid_i && wb1_rdAddr_i == 5'(r)};
        sum = {1'b0, sb_cnt_q[r]} + (SB_CNT_W+1)'(inc);
        // Underflow clamps at zero and flags the stray writeback.
        if (sum < (SB_CNT_W+1)'(dec)) begin
          sb_cnt_d[r] = '0;
          sb_err_d    = 1'b1;
        end else begin
          sb_cnt_d[r] = SB_CNT_W'(sum - (SB_CNT_W+1)'(dec));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_pid_q <= '0;
      sb_err_q  <= 1'b0;
      for (int r = 0; r < 32; r++) sb_cnt_q[r] <= '0;
    end else begin
      exp_pid_q <= exp_pid_d;
      sb_err_q  <= sb_err_d;
      for (int r = 0; r < 32; r++) sb_cnt_q[r] <= sb_cnt_d[r];
    end
  end

endmodule
